// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and the fetch packet type
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_WIDTH = 32;
    localparam int PC_STEP     = 4;

    // Canonical addi x0,x0,0; kept for a decode-side bubble
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [XLEN-1:0]        pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - generic 2-entry synchronous FIFO with flush
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic [1:0]       count;
    logic             pop_eff;
    logic             push_eff;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign head     = entry0;
    assign pop_eff  = pop && !empty;
    assign push_eff = push && (!full || pop_eff);

    // entry0 is always the head; it is left untouched when the FIFO drains
    // so the output keeps showing the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push_eff && pop_eff) begin
            if (count == 2'd1) begin
                entry0 <= wdata;
            end else begin
                entry0 <= entry1;
                entry1 <= wdata;
            end
        end else if (push_eff) begin
            if (count == 2'd0) begin
                entry0 <= wdata;
            end else begin
                entry1 <= wdata;
            end
            count <= count + 2'd1;
        end else if (pop_eff) begin
            if (count == 2'd2) begin
                entry0 <= entry1;
            end
            count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, redirect handling, buffered decode interface
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    logic [ADDR_WIDTH-1:0]        pc;
    logic                         pop;
    logic                         fetch;
    logic                         fifo_full;
    logic                         fifo_empty;
    fetch_pkt_t                   wr_pkt;
    fetch_pkt_t                   head_pkt;
    logic [$bits(fetch_pkt_t)-1:0] head_bits;
    logic                         unused_pc_hi;

    assign imem_addr = pc;
    assign out_valid = !fifo_empty;

    // A pop coinciding with a redirect is void: the head is flushed, not consumed.
    assign pop   = out_valid && out_ready && !redirect_valid;
    assign fetch = !redirect_valid && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        end else if (fetch) begin
            pc <= pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    assign wr_pkt.instr = imem_data;
    assign wr_pkt.pc    = XLEN'(pc);

    fetch_fifo #(
        .WIDTH ($bits(fetch_pkt_t))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fetch),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_pkt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head_bits)
    );

    assign head_pkt     = fetch_pkt_t'(head_bits);
    assign out_instr    = head_pkt.instr;
    assign out_pc       = head_pkt.pc[ADDR_WIDTH-1:0];
    assign unused_pc_hi = ^head_pkt.pc[XLEN-1:ADDR_WIDTH];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [3:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [3:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_pc;

    int checks = 0;
    int errors = 0;

    int q[$];
    int m_pc;
    int m_last;
    bit m_last_vld;
    int acc_next;
    int acc_count;

    typedef struct {
        bit         ready;
        bit         redir;
        logic [3:0] rpc;
        bit         ev;
        logic [3:0] epc;
        logic [3:0] eaddr;
    } vec_t;

    vec_t tv[16];

    instruction_fetch #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (4),
        .RESET_PC   (4'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: byte at address a holds a+1, little-endian words.
    function automatic logic [31:0] word_at(input logic [3:0] a);
        logic [7:0] b;
        b = {4'h0, a[3:2], 2'b00} + 8'd1;
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    assign imem_data = word_at(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc       = 0;
        m_last_vld = 0;
        acc_next   = 0;
    endtask

    task automatic model_check(input string name);
        chk({name, " valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({name, " addr"}, 32'(imem_addr), 32'(m_pc));
        if (q.size() != 0) begin
            chk({name, " pc"}, 32'(out_pc), 32'(q[0]));
            chk({name, " instr"}, out_instr, word_at(4'(q[0])));
        end else if (m_last_vld) begin
            chk({name, " hold pc"}, 32'(out_pc), 32'(m_last));
            chk({name, " hold instr"}, out_instr, word_at(4'(m_last)));
        end else begin
            chk({name, " rst pc"}, 32'(out_pc), 32'd0);
            chk({name, " rst instr"}, out_instr, 32'd0);
        end
    endtask

    // Queue-level model of one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit pop;
        bit fetch;
        pop   = (q.size() != 0) && out_ready && !redirect_valid;
        fetch = !redirect_valid && ((q.size() < 2) || pop);
        if (redirect_valid) begin
            q.delete();
            m_pc = int'(redirect_pc) & 12;
        end else begin
            if (pop) void'(q.pop_front());
            if (fetch) begin
                q.push_back(m_pc);
                m_pc = (m_pc + 4) % 16;
            end
        end
        if (q.size() != 0) begin
            m_last     = q[0];
            m_last_vld = 1;
        end
    endtask

    task automatic tick(input string name);
        if (out_valid && out_ready && !redirect_valid) begin
            chk({name, " accepted pc"}, 32'(out_pc), 32'(acc_next));
            chk({name, " accepted instr"}, out_instr, word_at(out_pc));
            acc_next = (acc_next + 4) % 16;
            acc_count++;
        end
        if (redirect_valid) acc_next = int'(redirect_pc) & 12;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        model_check(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 4'd0;
        model_reset();
        #1;
        model_check("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tv = '{
            '{1, 0, 4'd0,  1, 4'd0,  4'd4},
            '{1, 0, 4'd0,  1, 4'd4,  4'd8},
            '{1, 0, 4'd0,  1, 4'd8,  4'd12},
            '{1, 0, 4'd0,  1, 4'd12, 4'd0},
            '{1, 0, 4'd0,  1, 4'd0,  4'd4},
            '{0, 0, 4'd0,  1, 4'd0,  4'd8},
            '{0, 0, 4'd0,  1, 4'd0,  4'd8},
            '{1, 1, 4'd12, 0, 4'd0,  4'd12},
            '{1, 0, 4'd0,  1, 4'd12, 4'd0},
            '{1, 0, 4'd0,  1, 4'd0,  4'd4},
            '{1, 1, 4'd7,  0, 4'd0,  4'd4},
            '{1, 0, 4'd0,  1, 4'd4,  4'd8},
            '{1, 1, 4'd8,  0, 4'd0,  4'd8},
            '{0, 1, 4'd13, 0, 4'd0,  4'd12},
            '{0, 0, 4'd0,  1, 4'd12, 4'd0},
            '{1, 0, 4'd0,  1, 4'd0,  4'd4}
        };

        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 4'd0;
        acc_count      = 0;
        model_reset();

        // Streaming, wrap, full stall, redirects (aligned, misaligned, back-to-back)
        do_reset();
        for (int i = 0; i < 16; i++) begin
            out_ready      = tv[i].ready;
            redirect_valid = tv[i].redir;
            redirect_pc    = tv[i].rpc;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl valid", i), 32'(out_valid), 32'(tv[i].ev));
            if (tv[i].ev) chk($sformatf("vec%0d tbl pc", i), 32'(out_pc), 32'(tv[i].epc));
            chk($sformatf("vec%0d tbl addr", i), 32'(imem_addr), 32'(tv[i].eaddr));
        end
        redirect_valid = 1'b0;

        // Stall with decode not ready, then drain
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick($sformatf("stall%0d", i));
        chk("stall count", 32'(dut.u_fifo.count), 32'd2);
        chk("stall addr", 32'(imem_addr), 32'd8);
        out_ready = 1'b1;
        acc_count = 0;
        for (int i = 0; i < 3; i++) tick($sformatf("drain%0d", i));
        chk("drain accepted", 32'(acc_count), 32'd3);

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) tick($sformatf("pre_rst%0d", i));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(out_valid), 32'd0);
        chk("async rst addr", 32'(imem_addr), 32'd0);
        model_reset();
        @(negedge clk);
        model_check("async rst held");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick("post_rst");
        chk("post_rst pc", 32'(out_pc), 32'd0);
        chk("post_rst instr", out_instr, 32'h04030201);

        // Random decode back-pressure, no redirects
        do_reset();
        acc_count = 0;
        for (int i = 0; i < 200; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick($sformatf("rand%0d", i));
        end
        chk("rand progress", 32'(acc_count >= 40), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V core. It sits directly upstream of `instruction_memory`: it owns the program counter, drives the memory's byte address, and captures the returned little-endian 32-bit word. Each word is delivered with its PC to decode through a 2-entry buffered valid/ready interface. Decode stalls, and redirects from branch/jump resolution, are absorbed here without losing or duplicating instructions.

## Interface
- `DATA_WIDTH`, 32: instruction width. Only 32 is supported.
- `ADDR_WIDTH`, 4: byte-address width. It must match `instruction_memory`.
- `RESET_PC`, 0: PC loaded at reset. Word-aligned.

- `clk`  in  1: single clock; all state is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  ADDR_WIDTH: byte address to `instruction_memory`. Equals `pc`, combinationally.
- `imem_data`  in  DATA_WIDTH: combinational instruction word returned for `imem_addr`.
- `redirect_valid`  in  1: load a new PC this cycle.
- `redirect_pc`  in  ADDR_WIDTH: target PC. Bits [1:0] are ignored and treated as 0.
- `out_valid`  out  1: `out_instr`/`out_pc` hold a fetched instruction.
- `out_ready`  in  1: decode accepts the word. A transfer happens when `out_valid && out_ready`.
- `out_instr`  out  DATA_WIDTH: instruction at the buffer head.
- `out_pc`  out  ADDR_WIDTH: byte address of `out_instr`.

## Operation
- State:
  - `pc`, ADDR_WIDTH bits.
  - 2-entry FIFO of {instr, pc}.
  - `count`, 0..2.
- Reset (async, while `rst_n`=0):
  - `pc`=RESET_PC, `count`=0.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0.
  - `imem_addr`=RESET_PC.
- `pop` = `out_valid && out_ready`.
- `fetch` = !`redirect_valid` && (`count`<2 || `pop`).
- Normal edge with `fetch`:
  - push {`imem_data`, `pc`} into the FIFO.
  - `pc` <= `pc`+4, modulo 2^ADDR_WIDTH. The last word wraps to 0.
- Edge without `fetch` and without redirect: `pc` holds. `imem_addr` is therefore re-presented until the word is captured.
- Redirect edge (`redirect_valid`=1):
  - Redirect has priority over everything else.
  - The FIFO is flushed (`count`<=0) and any simultaneous pop is void. Decode must not treat that cycle's head as consumed.
  - No push occurs.
  - `pc` <= {`redirect_pc`[ADDR_WIDTH-1:2], 2'b00}.
- Simultaneous push and pop: `count` is unchanged, and the head advances to the next entry.
- Full with no pop: `fetch`=0 and `pc` is stable. No instruction is lost.
- Empty: `out_valid`=0. `out_instr`/`out_pc` hold their last value, or 0 after reset.
- FIFO order is strict, and each fetched PC is delivered exactly once between redirects.

## Timing
- `imem_addr` is combinational from the `pc` register only. There is no input-to-`imem_addr` path.
- Fetch latency: a word at `pc` is captured at the edge it is fetched, and `out_valid`=1 from that edge on. After reset release, `out_valid` rises after the 1st edge.
- Throughput is 1 instruction/cycle while `out_ready`=1 and there is no redirect.
- Redirect at edge t:
  - `out_valid`=0 after t.
  - The target word is pushed at edge t+1, so `out_valid`=1 after t+1.
  - Redirect penalty: 1 bubble.
- Back-to-back redirects: the last one wins. There is no push until the first edge without `redirect_valid`.
- Reset asserted mid-stream: everything clears immediately. The first fetch after release is from RESET_PC.
- Combinational path `out_ready`→`fetch` exists only inside the FIFO write enable. It does not reach any output port.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`.
  - `INSTR_WIDTH`.
  - `PC_STEP` (=4).
  - `NOP_INSTR` (32'h00000013, reserved for a later decode bubble).
  - typedef `fetch_pkt_t` {instr, pc}.
- One sub-module, `fetch_fifo`:
  - generic 2-entry synchronous FIFO, width `$bits(fetch_pkt_t)`.
  - ports: push, pop, flush, full, empty, head.
- The top level holds `pc`, the fetch/redirect logic, and port wiring.

## Test plan
Bench memory is loaded as in `instruction_memory`: addr 0=04030201, 4=08070605, 8=0c0b0a09, 12=100f0e0d. Parameters: ADDR_WIDTH=4, RESET_PC=0.

1. Reset then `out_ready`=1 for 5 cycles:
   - `out_instr`/`out_pc` sequence is 04030201/0, 08070605/4, 0c0b0a09/8, 100f0e0d/12, 04030201/0 (wrap).
   - `out_valid` stays high from the 1st edge on.
2. `out_ready`=0 for 4 cycles after reset:
   - `count` reaches 2 and `imem_addr` holds at 8.
   - Then `out_ready`=1: words at 0, 4, 8 appear in order, with no loss or duplicate.
3. Redirect to 12 while the FIFO holds 0 and 4:
   - `out_valid`=0 the next cycle.
   - Then 100f0e0d/12, followed by 04030201/0.
4. Redirect with `redirect_pc`=7:
   - the fetch resumes at 4 (08070605).
   - A pop asserted in the redirect cycle is discarded.
5. Assert `rst_n`=0 asynchronously mid-stream, between edges:
   - `out_valid`=0 and `imem_addr`=0 immediately.
   - After release, the stream restarts at 04030201/0.
6. Random `out_ready` toggling for 200 cycles without redirect:
   - the accepted PC sequence is 0, 4, 8, 12, 0, … exactly.
   - Each `out_instr` matches the memory content at its `out_pc`.
